// File: rtl/video_timing_ctrl.sv
// ---------------------------------------------------------------------------------------------
// video_timing_ctrl
//
// Raster timing generator for the DVI output stage. It produces hsync/vsync/vde, pixel
// coordinates and a frame-start pulse in the pixel clock domain, and it schedules line
// prefetches through a per-line request/acknowledge handshake with the line-buffer filler.
// A sticky underrun flag records a fetch that was not acknowledged before its line began.
//
// Ports:
//   pixclk       in   pixel clock, the only clock
//   rst          in   synchronous reset, active-high
//   enable       in   1 = timing advances, 0 = everything freezes
//   hsync        out  horizontal sync, asserted level HS_POL
//   vsync        out  vertical sync, asserted level VS_POL
//   vde          out  video data enable (active area)
//   x            out  current pixel column (valid when vde=1)
//   y            out  current line
//   frame_start  out  one-cycle pulse coincident with pixel (0,0)
//   line_req     out  fetch request for line line_num
//   line_num     out  line to fetch, stable while line_req=1
//   line_ack     in   fetcher accepts the request
//   underrun     out  sticky: a fetch was not acked before its line began
//   underrun_clr in   clears underrun (a simultaneous set wins)
// ---------------------------------------------------------------------------------------------
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter int unsigned FETCH_LEAD = 32
) (
    input  logic        pixclk,
    input  logic        rst,
    input  logic        enable,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        frame_start,
    output logic        line_req,
    output logic [9:0]  line_num,
    input  logic        line_ack,
    output logic        underrun,
    input  logic        underrun_clr
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] FETCH_H  = 11'(H_TOTAL - FETCH_LEAD);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {StIdle, StReq} fetch_state_e;

    logic [10:0]  h_cnt_q;
    logic [9:0]   v_cnt_q;
    logic         h_wrap;
    logic [9:0]   next_line;

    logic         vde_d;
    logic         hsync_d;
    logic         vsync_d;
    logic         frame_start_d;

    fetch_state_e state_q, state_d;
    logic         line_req_d;
    logic [9:0]   line_num_d;
    logic         underrun_set;
    logic         underrun_d;

    // ----------------------------------------------------------------------------------------
    // Raster counters
    // ----------------------------------------------------------------------------------------
    always_comb begin
        h_wrap    = (h_cnt_q == H_LAST);
        // Line that follows the current one, wrapping at the end of the frame.
        next_line = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            h_cnt_q <= 11'd0;
            v_cnt_q <= 10'd0;
        end else if (enable) begin
            if (h_wrap) begin
                h_cnt_q <= 11'd0;
                v_cnt_q <= next_line;
            end else begin
                h_cnt_q <= h_cnt_q + 11'd1;
            end
        end
    end

    // ----------------------------------------------------------------------------------------
    // Output decode (registered, one cycle behind the counters)
    // ----------------------------------------------------------------------------------------
    always_comb begin
        vde_d         = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hsync_d       = ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
        // vsync depends only on the line, so it switches at h=0.
        vsync_d       = ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
        frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 10'd0);
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            vde         <= 1'b0;
            x           <= 11'd0;
            y           <= 10'd0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else if (enable) begin
            vde         <= vde_d;
            x           <= h_cnt_q;
            y           <= v_cnt_q;
            hsync       <= hsync_d;
            vsync       <= vsync_d;
            frame_start <= frame_start_d;
        end
    end

    // ----------------------------------------------------------------------------------------
    // Line fetch FSM
    // ----------------------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        line_req_d   = line_req;
        line_num_d   = line_num;
        underrun_set = 1'b0;
        if (enable) begin
            unique case (state_q)
                StIdle: begin
                    // Only visible lines are fetched; line 0 is requested from the last line.
                    if ((h_cnt_q == FETCH_H) && (next_line < V_ACT)) begin
                        state_d    = StReq;
                        line_req_d = 1'b1;
                        line_num_d = next_line;
                    end
                end
                StReq: begin
                    if (line_ack) begin
                        // An ack on the wrap cycle itself is still on time.
                        state_d    = StIdle;
                        line_req_d = 1'b0;
                    end else if (h_wrap && (next_line == line_num)) begin
                        // The requested line is starting unfetched: abandon the request.
                        state_d      = StIdle;
                        line_req_d   = 1'b0;
                        underrun_set = 1'b1;
                    end
                end
                default: begin
                    state_d    = StIdle;
                    line_req_d = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        underrun_d = underrun;
        if (enable) begin
            if (underrun_set) begin
                underrun_d = 1'b1;
            end else if (underrun_clr) begin
                underrun_d = 1'b0;
            end
        end
    end

    always_ff @(posedge pixclk) begin
        if (rst) begin
            state_q  <= StIdle;
            line_req <= 1'b0;
            line_num <= 10'd0;
            underrun <= 1'b0;
        end else begin
            state_q  <= state_d;
            line_req <= line_req_d;
            line_num <= line_num_d;
            underrun <= underrun_d;
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_video_timing_ctrl
//
// Self-checking bench for video_timing_ctrl on a small raster (24x10 total) so that whole
// frames fit in a short run. A behavioural model tracks the raster as a single linear pixel
// index and derives (h,v), sync levels and fetch events from it arithmetically.
// ---------------------------------------------------------------------------------------------
module tb_video_timing_ctrl;

    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int LEAD = 8;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;

    logic        pixclk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        line_ack = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        hsync, vsync, vde, frame_start, line_req, underrun;
    logic [10:0] x;
    logic [9:0]  y;
    logic [9:0]  line_num;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int t = 0;            // linear pixel index of the counters, 0..HT*VT-1
    bit m_req = 0;
    int m_num = 0;
    bit m_und = 0;
    bit e_vde = 0, e_hs = !HSP, e_vs = !VSP, e_fs = 0;
    int e_x = 0, e_y = 0;

    // Frame statistics
    bit have_prev = 0;
    int since = 0, dis = 0, vcnt = 0;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .FETCH_LEAD(LEAD)
    ) dut (
        .pixclk       (pixclk),
        .rst          (rst),
        .enable       (enable),
        .hsync        (hsync),
        .vsync        (vsync),
        .vde          (vde),
        .x            (x),
        .y            (y),
        .frame_start  (frame_start),
        .line_req     (line_req),
        .line_num     (line_num),
        .line_ack     (line_ack),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 pixclk = ~pixclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same cycle and compare outputs.
    task automatic step(input logic en, input logic a, input logic c, input logic r);
        int h, v, nl;
        bit set;
        enable = en; line_ack = a; underrun_clr = c; rst = r;
        @(posedge pixclk);
        #1;
        if (r) begin
            t = 0; m_req = 0; m_num = 0; m_und = 0;
            e_vde = 0; e_x = 0; e_y = 0; e_fs = 0; e_hs = !HSP; e_vs = !VSP;
            have_prev = 0;
        end else if (en) begin
            h = t % HT;
            v = t / HT;
            nl = (v + 1) % VT;
            e_vde = (h < HA) && (v < VA);
            e_x = h;
            e_y = v;
            e_hs = (h >= HA + HFP && h < HA + HFP + HSW) ? HSP : !HSP;
            e_vs = (v >= VA + VFP && v < VA + VFP + VSW) ? VSP : !VSP;
            e_fs = (t == 0);
            set = 0;
            if (m_req) begin
                if (a) m_req = 0;
                else if (h == HT - 1 && nl == m_num) begin
                    m_req = 0;
                    set = 1;
                end
            end else if (h == HT - LEAD && nl < VA) begin
                m_req = 1;
                m_num = nl;
            end
            if (set) m_und = 1;
            else if (c) m_und = 0;
            t = (t + 1) % (HT * VT);
        end
        check("hsync", hsync, e_hs);
        check("vsync", vsync, e_vs);
        check("vde", vde, e_vde);
        check("x", x, e_x);
        check("y", y, e_y);
        check("frame_start", frame_start, e_fs);
        check("line_req", line_req, m_req);
        check("line_num", line_num, m_num);
        check("underrun", underrun, m_und);

        since++;
        if (!en) dis++;
        if (!r && en && frame_start) begin
            if (have_prev) begin
                check("fs_period", since, HT * VT + dis);
                check("vde_per_frame", vcnt, HA * VA);
            end
            have_prev = 1; since = 0; dis = 0; vcnt = 0;
        end
        if (!r && en && vde) vcnt++;
    endtask

    task automatic flush_req();
        int n = 0;
        while (line_req && n < 10) begin step(1'b1, 1'b1, 1'b0, 1'b0); n++; end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!line_req && n < 2 * HT * VT) begin step(1'b1, 1'b0, 1'b0, 1'b0); n++; end
        check("req_seen", line_req, 1);
    endtask

    initial begin
        // Reset for three cycles
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        // Three enabled frames with a prompt fetcher
        for (int i = 0; i < 3 * HT * VT; i++) step(1'b1, line_req, 1'b0, 1'b0);

        // Ack on the fifth cycle of the request: line_req is high exactly five cycles
        flush_req();
        wait_req();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("req_still_high", line_req, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("req_dropped", line_req, 0);

        // Underrun with clear held: set wins on the wrap cycle, then a lone clear works
        wait_req();
        begin
            int n = 0;
            while (line_req && n < HT) begin step(1'b1, 1'b0, 1'b1, 1'b0); n++; end
        end
        check("underrun_set_wins", underrun, 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("underrun_sticky", underrun, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("underrun_cleared", underrun, 0);

        // Freeze for 7 cycles while a request is pending, then ack
        wait_req();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("no_spurious_underrun", underrun, 0);
        for (int i = 0; i < 2 * HT * VT; i++) step(1'b1, line_req, 1'b0, 1'b0);

        // Reset mid-frame with a request outstanding
        wait_req();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("rst_req", line_req, 0);
        check("rst_vde", vde, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("rst_fs", frame_start, 1);

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            step(($urandom % 10) != 0, ($urandom % 4) == 0, ($urandom % 20) == 0,
                 ($urandom % 2000) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/video_timing_ctrl.md
Name: video_timing_ctrl

Overview:
Generates the raster timing that drives the DVI output stage: hSync, vSync, vde, pixel coordinates and a frame-start pulse, all in the pixel clock domain. It also schedules line prefetches. It issues a per-line request/acknowledge handshake to the line-buffer filler ahead of each active line, and flags a sticky underrun when a fetch is not acknowledged in time. It sits between the video memory fetch logic and the TMDS/DVI serializer.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of hsync (0 = active-low)
VS_POL, 0, asserted level of vsync
FETCH_LEAD, 32, pixels before end of line at which the next line's fetch is requested; range 1..H_TOTAL-1

Ports:
pixclk  in  1  pixel clock; the only clock
rst  in  1  synchronous reset, active-high
enable  in  1  1 = timing advances; 0 = freeze
hsync  out  1  horizontal sync, polarity per HS_POL
vsync  out  1  vertical sync, polarity per VS_POL
vde  out  1  video data enable (active area)
x  out  11  current pixel column; valid when vde=1
y  out  10  current line
frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
line_req  out  1  fetch request for line line_num
line_num  out  10  line to fetch; stable while line_req=1
line_ack  in  1  fetcher accepts the request
underrun  out  1  sticky: a fetch was not acked before its line began
underrun_clr  in  1  clears underrun

Behaviour:
- Clock and reset: one clock, pixclk; rst is synchronous, active-high.
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counters: h_cnt runs 0..H_TOTAL-1. v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
  - Both advance only on cycles with enable=1.
  - Both wrap to 0, and v wraps at the end of the last line.
- Output decode, registered (1-cycle latency): on the cycle after the counters hold (h,v):
  - vde = (h<H_ACTIVE && v<V_ACTIVE)
  - x = h, y = v
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (whole lines, changes at h=0)
  - frame_start = (h==0 && v==0)
- enable=0: counters, all outputs and the fetch FSM hold their values. No underrun detection occurs.
- Reset values:
  - h_cnt=v_cnt=0; FSM=IDLE.
  - vde=0, x=0, y=0, frame_start=0, line_req=0, line_num=0, underrun=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - The first enabled cycle after reset shows (0,0) on outputs the following cycle, with frame_start=1.
- Fetch FSM has two states, IDLE and REQ.
  - IDLE→REQ: on an enabled cycle with h_cnt==H_TOTAL-FETCH_LEAD, if nl=(v_cnt==V_TOTAL-1 ? 0 : v_cnt+1) < V_ACTIVE. On that transition line_num<=nl and line_req<=1.
  - REQ: line_req stays 1. line_ack=1 sampled while line_req=1 → IDLE and line_req<=0 next cycle.
  - line_ack while in IDLE is ignored.
  - Line 0 of the next frame is requested during the last line of the current frame (wrap case).
- Underrun:
  - Triggered when, in REQ, the counters wrap to h_cnt=0 on line line_num without ack having been sampled.
  - Effects: underrun<=1; line_req<=0; FSM→IDLE; the request is abandoned.
  - An ack on that same wrap cycle counts as on time: no underrun.
- underrun_clr: clears underrun. If set and clear occur in the same cycle, set wins.
- rst mid-frame: all state returns to reset values next cycle. An outstanding line_req is dropped with no ack required.
- Widths: x is 11 bits to cover H_TOTAL up to 2047; V_TOTAL must be ≤1024.

Test Plan:
- Reset/default 640x480: assert rst 3 cycles then enable=1 → reset values as listed. (0,0) appears with frame_start=1. Exactly 420000 cycles elapse between frame_start pulses, and exactly 307200 vde=1 cycles occur per frame.
- Sync shape, default params: hsync low for exactly 96 cycles starting at output x=656 on each line. vsync low for exactly 2×800 cycles starting at y=490, x=0.
- Fetch timing, default params:
  - At v=10, h=768: line_req rises with line_num=11. With ack after 5 cycles, line_req is high exactly 5 cycles.
  - On v=479: no request.
  - On v=524: line_num=0.
- Underrun: hold line_ack=0 → at the wrap into line_num, line_req falls and underrun=1 stays set. underrun_clr=1 in the same cycle as a new underrun → underrun remains 1. A later lone clr → 0.
- enable toggling: drop enable for 7 cycles mid-line and mid-REQ → all outputs frozen. The frame period is extended by exactly 7 cycles, and no spurious underrun occurs.
- Reset mid-frame: assert rst at v=200 with line_req=1 → next cycle line_req=0, vde=0, and counters restart at (0,0).
